xgmii_ptp_frame_tx: RTL and testbench

//  Transmit-side XGMII framer for the PTPv2 datapath (tx_clk domain).
//  - Accepts frame bytes (DA..payload, no preamble/FCS) on a 64-bit valid/ready stream.
//  - Emits 64-bit XGMII: start/preamble word, data, appended CRC-32 FCS, /T/, IPG idles.
//  - Output feeds the tx-side timestamp unit input (xge_txd_i/xge_txc_i).

---
 rtl/xgmii_ptp_frame_tx.sv | 192 +++++++++++++++++++
 tb/tb_xgmii_ptp_frame_tx.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_ptp_frame_tx.sv
// Transmit-side XGMII framer: start/preamble word, payload, CRC-32 FCS, /T/ and IPG idles.
// Underrun aborts the frame with an error word and discards the rest of it.
module xgmii_ptp_frame_tx #(
  parameter int unsigned IPG_WORDS = 2
) (
  input  logic        tx_clk,
  input  logic        tx_rst_n,
  input  logic        tx_clk_en_i,
  input  logic [63:0] s_data_i,
  input  logic        s_valid_i,
  input  logic        s_last_i,
  input  logic [2:0]  s_bytes_i,
  output logic        s_ready_o,
  output logic [63:0] xge_txd_o,
  output logic [7:0]  xge_txc_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] underrun_cnt_o
);

  localparam logic [63:0] IdleWord  = 64'h0707070707070707;
  localparam logic [63:0] StartWord = 64'hD5555555555555FB;
  localparam logic [63:0] ErrorWord = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] TermWord  = 64'h07070707070707FD;
  localparam int unsigned CntW      = (IPG_WORDS > 1) ? $clog2(IPG_WORDS) : 1;

  typedef enum logic [2:0] {StIdle, StData, StTail, StDrop, StIpg} state_e;

  state_e            state_q, state_d;
  logic [31:0]       crc_q, crc_d;
  logic [63:0]       txd_q, txd_d, tail_txd_q, tail_txd_d;
  logic [7:0]        txc_q, txc_d, tail_txc_q, tail_txc_d;
  logic              abort_q, abort_d;
  logic [CntW-1:0]   ipg_cnt_q, ipg_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d, underrun_cnt_q, underrun_cnt_d;

  logic [3:0]        n_bytes;
  logic [31:0]       crc_beat, fcs;
  logic [127:0]      pack_d;
  logic [15:0]       pack_c;

  function automatic logic [31:0] crc_update(logic [31:0] crc, logic [63:0] data,
                                             logic [3:0] nbytes);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nbytes) begin
        c = c ^ {24'h0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  assign n_bytes  = (s_bytes_i == 3'd0) ? 4'd8 : {1'b0, s_bytes_i};
  assign crc_beat = crc_update(crc_q, s_data_i, s_last_i ? n_bytes : 4'd8);
  assign fcs      = ~crc_beat;

  // Last beat laid out over two words: data, FCS (LSB first), /T/, idle fill.
  always_comb begin
    int nb;
    nb     = int'(n_bytes);
    pack_d = '0;
    pack_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < nb) begin
        pack_d[8*i +: 8] = 8'(s_data_i >> (8 * i));
      end else if (i < nb + 4) begin
        pack_d[8*i +: 8] = 8'(fcs >> (8 * (i - nb)));
      end else if (i == nb + 4) begin
        pack_d[8*i +: 8] = 8'hFD;
        pack_c[i]        = 1'b1;
      end else begin
        pack_d[8*i +: 8] = 8'h07;
        pack_c[i]        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    crc_d          = crc_q;
    txd_d          = IdleWord;
    txc_d          = 8'hFF;
    tail_txd_d     = tail_txd_q;
    tail_txc_d     = tail_txc_q;
    abort_d        = abort_q;
    ipg_cnt_d      = ipg_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    unique case (state_q)
      StIdle: begin
        crc_d = 32'hFFFFFFFF;
        if (s_valid_i) begin
          txd_d   = StartWord;
          txc_d   = 8'h01;
          state_d = StData;
        end
      end
      StData: begin
        if (!s_valid_i) begin
          txd_d      = ErrorWord;
          tail_txd_d = TermWord;
          tail_txc_d = 8'hFF;
          abort_d    = 1'b1;
          crc_d      = 32'hFFFFFFFF;
          state_d    = StTail;
        end else if (!s_last_i) begin
          txd_d = s_data_i;
          txc_d = 8'h00;
          crc_d = crc_beat;
        end else begin
          txd_d = pack_d[63:0];
          txc_d = pack_c[7:0];
          crc_d = 32'hFFFFFFFF;
          if (n_bytes <= 4'd3) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            ipg_cnt_d   = '0;
            state_d     = StIpg;
          end else begin
            tail_txd_d = pack_d[127:64];
            tail_txc_d = pack_c[15:8];
            abort_d    = 1'b0;
            state_d    = StTail;
          end
        end
      end
      StTail: begin
        txd_d = tail_txd_q;
        txc_d = tail_txc_q;
        if (abort_q) begin
          underrun_cnt_d = underrun_cnt_q + 16'd1;
          state_d        = StDrop;
        end else begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          ipg_cnt_d   = '0;
          state_d     = StIpg;
        end
      end
      StDrop: begin
        if (s_valid_i && s_last_i) begin
          ipg_cnt_d = '0;
          state_d   = StIpg;
        end
      end
      StIpg: begin
        if (ipg_cnt_q == CntW'(IPG_WORDS - 1)) begin
          state_d = StIdle;
        end else begin
          ipg_cnt_d = ipg_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state_q        <= StIdle;
      crc_q          <= 32'hFFFFFFFF;
      txd_q          <= IdleWord;
      txc_q          <= 8'hFF;
      tail_txd_q     <= IdleWord;
      tail_txc_q     <= 8'hFF;
      abort_q        <= 1'b0;
      ipg_cnt_q      <= '0;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else if (tx_clk_en_i) begin
      state_q        <= state_d;
      crc_q          <= crc_d;
      txd_q          <= txd_d;
      txc_q          <= txc_d;
      tail_txd_q     <= tail_txd_d;
      tail_txc_q     <= tail_txc_d;
      abort_q        <= abort_d;
      ipg_cnt_q      <= ipg_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign s_ready_o      = ((state_q == StData) || (state_q == StDrop)) && tx_clk_en_i;
  assign xge_txd_o      = txd_q;
  assign xge_txc_o      = txc_q;
  assign busy_o         = (state_q != StIdle);
  assign frame_cnt_o    = frame_cnt_q;
  assign underrun_cnt_o = underrun_cnt_q;

endmodule

// File: tb/tb_xgmii_ptp_frame_tx.sv
// Bench for xgmii_ptp_frame_tx: frames are turned into expected XGMII word lists from the
// byte-level framing rules and compared word by word on every enabled cycle.
module tb_xgmii_ptp_frame_tx;

  localparam int unsigned IPG_WORDS = 2;
  localparam logic [63:0] IDLE  = 64'h0707070707070707;
  localparam logic [63:0] START = 64'hD5555555555555FB;

  typedef logic [7:0] bq_t[$];
  typedef enum logic [1:0] {KData, KTerm, KAbort, KIpg} kind_e;
  typedef struct packed {
    logic [63:0] txd;
    logic [7:0]  txc;
    kind_e       kind;
    logic        last;
  } item_t;

  logic        tx_clk = 1'b0;
  logic        tx_rst_n = 1'b0;
  logic        tx_clk_en_i = 1'b1;
  logic [63:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_last_i = 1'b0;
  logic [2:0]  s_bytes_i = '0;
  logic        s_ready_o, busy_o;
  logic [63:0] xge_txd_o;
  logic [7:0]  xge_txc_o;
  logic [15:0] frame_cnt_o, underrun_cnt_o;

  always #5 tx_clk = ~tx_clk;

  xgmii_ptp_frame_tx #(.IPG_WORDS(IPG_WORDS)) dut (
    .tx_clk        (tx_clk),
    .tx_rst_n      (tx_rst_n),
    .tx_clk_en_i   (tx_clk_en_i),
    .s_data_i      (s_data_i),
    .s_valid_i     (s_valid_i),
    .s_last_i      (s_last_i),
    .s_bytes_i     (s_bytes_i),
    .s_ready_o     (s_ready_o),
    .xge_txd_o     (xge_txd_o),
    .xge_txc_o     (xge_txc_o),
    .busy_o        (busy_o),
    .frame_cnt_o   (frame_cnt_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  int    errors = 0;
  int    checks = 0;
  item_t exp_q[$];
  item_t log_q[$];
  bq_t   frm;
  bit    chk_on = 1'b0;
  bit    in_frame = 1'b0;
  bit    en_edge = 1'b0;
  bit    alt = 1'b0;
  int    exp_frames = 0;
  int    exp_under = 0;
  int    wait_cnt = 0;
  logic [63:0] prev_txd = IDLE;
  logic [7:0]  prev_txc = 8'hFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit pick_en(input int mode);
    alt = ~alt;
    if (mode == 1) return alt;
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  always @(posedge tx_clk) en_edge <= tx_clk_en_i;

  // Compare process: one expected word per enabled edge, held value otherwise.
  always @(negedge tx_clk) begin
    item_t it;
    if (chk_on) begin
      if (en_edge) begin
        if (!in_frame && exp_q.size() > 0 && xge_txd_o == START && xge_txc_o == 8'h01) begin
          in_frame = 1'b1;
          wait_cnt = 0;
        end
        if (in_frame) begin
          it = exp_q.pop_front();
          check("txd", xge_txd_o, it.txd);
          check("txc", 64'(xge_txc_o), 64'(it.txc));
          if (it.kind == KTerm) exp_frames++;
          if (it.kind == KAbort) exp_under++;
          if (it.kind != KIpg) begin
            check("busy", 64'(busy_o), 64'd1);
            log_q.push_back(it);
            log_q[log_q.size()-1].txd = xge_txd_o;
            log_q[log_q.size()-1].txc = xge_txc_o;
          end
          prev_txd = it.txd;
          prev_txc = it.txc;
          if (it.last) in_frame = 1'b0;
        end else begin
          check("idle_txd", xge_txd_o, IDLE);
          check("idle_txc", 64'(xge_txc_o), 64'hFF);
          prev_txd = IDLE;
          prev_txc = 8'hFF;
          if (exp_q.size() > 0) begin
            wait_cnt++;
            if (wait_cnt == 64) check("start_timeout", 64'(wait_cnt), 64'd0);
          end
        end
        check("frame_cnt", 64'(frame_cnt_o), 64'(16'(exp_frames)));
        check("underrun_cnt", 64'(underrun_cnt_o), 64'(16'(exp_under)));
      end else begin
        check("hold_txd", xge_txd_o, prev_txd);
        check("hold_txc", 64'(xge_txc_o), 64'(prev_txc));
      end
      if (!tx_clk_en_i) check("ready_gated", 64'(s_ready_o), 64'd0);
    end
  end

  // Expected words for the frame in frm, from byte-level framing rules.
  task automatic build_expected(input int drop_after);
    item_t it;
    bq_t   s;
    bit    c[$];
    logic [31:0] fcs;
    int    fd_pos;
    it = '{txd: START, txc: 8'h01, kind: KData, last: 1'b0};
    exp_q.push_back(it);
    if (drop_after < 0) begin
      fcs = crc32(frm);
      s = frm;
      foreach (frm[i]) c.push_back(1'b0);
      for (int k = 0; k < 4; k++) begin
        s.push_back(fcs[8*k +: 8]);
        c.push_back(1'b0);
      end
      fd_pos = s.size();
      s.push_back(8'hFD);
      c.push_back(1'b1);
      while (s.size() % 8 != 0) begin
        s.push_back(8'h07);
        c.push_back(1'b1);
      end
      for (int w = 0; w < s.size() / 8; w++) begin
        for (int l = 0; l < 8; l++) begin
          it.txd[8*l +: 8] = s[8*w + l];
          it.txc[l]        = c[8*w + l];
        end
        it.kind = (fd_pos / 8 == w) ? KTerm : KData;
        it.last = 1'b0;
        exp_q.push_back(it);
      end
      for (int g = 0; g < int'(IPG_WORDS); g++) begin
        it = '{txd: IDLE, txc: 8'hFF, kind: KIpg, last: (g == int'(IPG_WORDS) - 1)};
        exp_q.push_back(it);
      end
    end else begin
      for (int w = 0; w < drop_after; w++) begin
        for (int l = 0; l < 8; l++) it.txd[8*l +: 8] = frm[8*w + l];
        it.txc  = 8'h00;
        it.kind = KData;
        it.last = 1'b0;
        exp_q.push_back(it);
      end
      it = '{txd: 64'hFEFEFEFEFEFEFEFE, txc: 8'hFF, kind: KData, last: 1'b0};
      exp_q.push_back(it);
      it = '{txd: 64'h07070707070707FD, txc: 8'hFF, kind: KAbort, last: 1'b1};
      exp_q.push_back(it);
    end
  endtask

  task automatic drive_beat(input int i, input int nb, input int mode);
    @(negedge tx_clk);
    #1;
    for (int l = 0; l < 8; l++) begin
      s_data_i[8*l +: 8] = (8*i + l < frm.size()) ? frm[8*i + l] : 8'($urandom);
    end
    s_valid_i   = 1'b1;
    s_last_i    = (i == nb - 1);
    s_bytes_i   = 3'(frm.size() % 8);
    tx_clk_en_i = pick_en(mode);
  endtask

  task automatic send_frame(input int drop_after, input int mode);
    int  nb;
    int  i;
    int  budget;
    bit  dropped;
    nb      = (frm.size() + 7) / 8;
    i       = 0;
    budget  = 0;
    dropped = 1'b0;
    build_expected(drop_after);
    while (i < nb) begin
      if (drop_after >= 0 && i == drop_after && !dropped) begin
        @(negedge tx_clk);
        #1;
        s_valid_i   = 1'b0;
        tx_clk_en_i = 1'b1;
        @(posedge tx_clk);
        dropped = 1'b1;
      end else begin
        drive_beat(i, nb, mode);
        @(posedge tx_clk);
        if (s_valid_i && s_ready_o && tx_clk_en_i) i++;
      end
      budget++;
      if (budget > 2000) begin
        check("accept_timeout", 64'(i), 64'(nb));
        break;
      end
    end
    @(negedge tx_clk);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic gap(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      @(negedge tx_clk);
      #1;
      s_valid_i   = 1'b0;
      tx_clk_en_i = pick_en(mode);
      @(posedge tx_clk);
    end
  endtask

  task automatic rand_frame(input int len);
    frm.delete();
    for (int k = 0; k < len; k++) frm.push_back(8'($urandom));
  endtask

  initial begin
    int len, nb, drop, mode, acc;
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    check("rst_txd", xge_txd_o, IDLE);
    check("rst_txc", 64'(xge_txc_o), 64'hFF);
    check("rst_ready", 64'(s_ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt_o), 64'd0);
    check("rst_underrun_cnt", 64'(underrun_cnt_o), 64'd0);
    #1;
    tx_rst_n = 1'b1;
    chk_on   = 1'b1;
    gap(3, 0);

    // "123456789": known CRC 0xCBF43926.
    frm.delete();
    for (int k = 0; k < 9; k++) frm.push_back(8'h31 + 8'(k));
    log_q.delete();
    send_frame(-1, 0);
    gap(12, 0);
    check("9b_log_size", 64'(log_q.size()), 64'd3);
    check("9b_start", log_q[0].txd, 64'hD5555555555555FB);
    check("9b_data", log_q[1].txd, 64'h3837363534333231);
    check("9b_data_c", 64'(log_q[1].txc), 64'h00);
    check("9b_term", log_q[2].txd, 64'h0707FDCBF4392639);
    check("9b_term_c", 64'(log_q[2].txc), 64'hE0);
    check("9b_frame_cnt", 64'(frame_cnt_o), 64'd1);

    rand_frame(64);
    log_q.delete();
    send_frame(-1, 0);
    gap(12, 0);
    check("64b_last_c", 64'(log_q[8].txc), 64'h00);
    check("64b_tail_c", 64'(log_q[9].txc), 64'hF0);
    check("64b_tail_fd", 64'(log_q[9].txd[39:32]), 64'hFD);

    rand_frame(60);
    log_q.delete();
    send_frame(-1, 0);
    gap(12, 0);
    check("60b_last_c", 64'(log_q[8].txc), 64'h00);
    check("60b_tail", log_q[9].txd, 64'h07070707070707FD);
    check("60b_tail_c", 64'(log_q[9].txc), 64'hFF);

    rand_frame(64);
    log_q.delete();
    send_frame(2, 0);
    gap(12, 0);
    check("ur_err", log_q[3].txd, 64'hFEFEFEFEFEFEFEFE);
    check("ur_err_c", 64'(log_q[3].txc), 64'hFF);
    check("ur_term", log_q[4].txd, 64'h07070707070707FD);
    check("ur_underrun_cnt", 64'(underrun_cnt_o), 64'd1);
    check("ur_frame_cnt", 64'(frame_cnt_o), 64'd3);

    frm.delete();
    for (int k = 0; k < 9; k++) frm.push_back(8'h31 + 8'(k));
    send_frame(-1, 1);
    gap(12, 1);
    check("9b_en_frame_cnt", 64'(frame_cnt_o), 64'd4);

    for (int f = 0; f < 30; f++) begin
      len  = $urandom_range(1, 80);
      nb   = (len + 7) / 8;
      mode = $urandom_range(0, 2);
      drop = (nb >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, nb - 1) : -1;
      rand_frame(len);
      send_frame(drop, mode);
      gap($urandom_range(0, 6), mode);
    end
    gap(16, 0);
    check("drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a frame.
    chk_on = 1'b0;
    rand_frame(40);
    acc = 0;
    for (int k = 0; k < 200 && acc < 2; k++) begin
      drive_beat(acc, 5, 0);
      @(posedge tx_clk);
      if (s_valid_i && s_ready_o && tx_clk_en_i) acc++;
    end
    check("mid_accepted", 64'(acc), 64'd2);
    @(negedge tx_clk);
    #1;
    tx_rst_n = 1'b0;
    @(negedge tx_clk);
    check("mid_rst_txd", xge_txd_o, IDLE);
    check("mid_rst_txc", 64'(xge_txc_o), 64'hFF);
    check("mid_rst_ready", 64'(s_ready_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_frame_cnt", 64'(frame_cnt_o), 64'd0);
    check("mid_rst_underrun_cnt", 64'(underrun_cnt_o), 64'd0);
    #1;
    tx_rst_n  = 1'b1;
    s_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
